mem_stage_lsu: RTL and testbench

Load/store unit for the pipelined core's MEM stage. Sits between the EX/MEM pipeline register and the MEM/WB register, and produces ReadDataM for the MEM/WB register. Runs a req/ack handshake to the external data memory, which may take multiple cycles. While an access is outstanding, the unit asserts StallM to freeze the upstream stages. It performs byte/half alignment, sign/zero extension and misalignment detection.

---
 rtl/mem_stage_lsu.sv | 145 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-bus master with lane alignment,
// load sign/zero extension and misalignment detection; stalls upstream while busy.
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  dreq,
  output logic                  dwe,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic [3:0]            dbe,
  input  logic                  dack,
  input  logic [DATA_WIDTH-1:0] drdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state_q, state_d;
  logic                  dreq_q, dreq_d;
  logic                  dwe_q, dwe_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
  logic [3:0]            dbe_q, dbe_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            lo_q, lo_d;
  logic [2:0]            f3_q, f3_d;

  logic acc, is_b, is_h, is_w, mis;

  // Size decode: 00 byte, 01 half, anything with bit1 set is a word.
  assign acc  = MemReadM | MemWriteM;
  assign is_b = (Funct3M[1:0] == 2'b00);
  assign is_h = (Funct3M[1:0] == 2'b01);
  assign is_w = Funct3M[1];
  assign mis  = (is_h & ALUResultM[0]) | (is_w & (|ALUResultM[1:0]));

  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dbe_d    = dbe_q;
    rdata_d  = rdata_q;
    lo_d     = lo_q;
    f3_d     = f3_q;
    case (state_q)
      IDLE: begin
        if (acc && !mis) begin
          state_d = REQ;
          dreq_d  = 1'b1;
          dwe_d   = MemWriteM;
          daddr_d = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
          lo_d    = ALUResultM[1:0];
          f3_d    = Funct3M;
          rdata_d = '0;
          if (is_b) begin
            dbe_d    = 4'b0001 << ALUResultM[1:0];
            dwdata_d = {4{WriteDataM[7:0]}};
          end else if (is_h) begin
            dbe_d    = 4'b0011 << ALUResultM[1:0];
            dwdata_d = {2{WriteDataM[15:0]}};
          end else begin
            dbe_d    = 4'b1111;
            dwdata_d = WriteDataM;
          end
        end
      end
      REQ: begin
        if (dack) begin
          state_d = DONE;
          dreq_d  = 1'b0;
          rdata_d = dwe_q ? '0 : drdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dbe_q    <= '0;
      rdata_q  <= '0;
      lo_q     <= '0;
      f3_q     <= '0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dbe_q    <= dbe_d;
      rdata_q  <= rdata_d;
      lo_q     <= lo_d;
      f3_q     <= f3_d;
    end
  end

  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;

  assign shifted = rdata_q >> {lo_q, 3'b000};
  assign sel_b   = shifted[7:0];
  assign sel_h   = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ReadDataM = '0;
    if (state_q == DONE && !dwe_q) begin
      case (f3_q)
        3'b000:  ReadDataM = {{24{sel_b[7]}}, sel_b};
        3'b100:  ReadDataM = {24'h0, sel_b};
        3'b001:  ReadDataM = {{16{sel_h[15]}}, sel_h};
        3'b101:  ReadDataM = {16'h0, sel_h};
        default: ReadDataM = rdata_q;
      endcase
    end
  end

  // Stall/misalign are combinational on live inputs, so force them low while in reset.
  assign StallM    = rst & (((state_q == IDLE) & acc & ~mis) | (state_q == REQ));
  assign MisalignM = rst & (state_q == IDLE) & acc & mis;
  assign dreq      = dreq_q;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign dbe       = dbe_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads/stores with varied ack latency,
// misalignment, stray acks and reset abandoning an outstanding request.
module tb_mem_stage_lsu;

  logic        clk, rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, dreq, dwe, dack;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;

  int tests, fails;

  int          stall_n, dreq_n;
  logic [31:0] rdm, a_o, wd_o;
  logic [3:0]  be_o;
  logic        we_o, done_ok, early_nz;

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dack(dack), .drdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    MemReadM = 0; MemWriteM = 0; Funct3M = 3'b000;
    ALUResultM = 0; WriteDataM = 0;
  endtask

  // Issue one access and track it to DONE; ack comes in the ack_at'th REQ cycle.
  task automatic access(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at);
    @(posedge clk); #1;
    MemReadM = mr; MemWriteM = mw; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    stall_n = 0; dreq_n = 0; done_ok = 0; early_nz = 0; rdm = '1;
    for (int c = 0; c < 40 && !done_ok; c++) begin
      @(negedge clk);
      dack = 0;
      if (StallM) begin
        stall_n++;
        if (ReadDataM !== 32'h0) early_nz = 1;
      end
      if (dreq) begin
        dreq_n++;
        a_o = daddr; wd_o = dwdata; be_o = dbe; we_o = dwe;
        if (dreq_n == ack_at) begin dack = 1; drdata = rd; end
      end else if (!StallM && dreq_n > 0) begin
        rdm = ReadDataM; done_ok = 1;
      end
    end
    @(posedge clk); #1;
    clr_inputs(); dack = 0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 0; dack = 0; drdata = 0;
    clr_inputs();
    #3;
    chk("rst_dreq", {31'h0, dreq}, 0);
    chk("rst_stall", {31'h0, StallM}, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_dbe", {28'h0, dbe}, 0);
    chk("rst_dwdata", dwdata, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    // LW 0x100, ack in first REQ cycle
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1);
    chk("lw_done", {31'h0, done_ok}, 1);
    chk("lw_stall_cyc", stall_n, 2);
    chk("lw_dreq_cyc", dreq_n, 1);
    chk("lw_daddr", a_o, 32'h100);
    chk("lw_dbe", {28'h0, be_o}, 4'b1111);
    chk("lw_dwe", {31'h0, we_o}, 0);
    chk("lw_rdata", rdm, 32'hDEADBEEF);
    chk("lw_rdata_early", {31'h0, early_nz}, 0);

    // LB 0x203, ack in 4th REQ cycle
    access(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 4);
    chk("lb_daddr", a_o, 32'h200);
    chk("lb_dbe", {28'h0, be_o}, 4'b1000);
    chk("lb_stall_cyc", stall_n, 5);
    chk("lb_rdata", rdm, 32'hFFFFFF80);

    access(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 4);
    chk("lbu_stall_cyc", stall_n, 5);
    chk("lbu_rdata", rdm, 32'h00000080);

    // LH sign extension on the low half
    access(1, 0, 3'b001, 32'h600, 0, 32'h1234F00D, 2);
    chk("lh_dbe", {28'h0, be_o}, 4'b0011);
    chk("lh_rdata", rdm, 32'hFFFFF00D);

    // SH 0x302
    access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h55555555, 1);
    chk("sh_dwe", {31'h0, we_o}, 1);
    chk("sh_dbe", {28'h0, be_o}, 4'b1100);
    chk("sh_dwdata", wd_o, 32'hABCDABCD);
    chk("sh_daddr", a_o, 32'h300);
    chk("sh_rdata", rdm, 0);

    // SB with read+write both set is a store
    access(1, 1, 3'b000, 32'h701, 32'h000000A5, 32'h77777777, 1);
    chk("sb_dwe", {31'h0, we_o}, 1);
    chk("sb_dbe", {28'h0, be_o}, 4'b0010);
    chk("sb_dwdata", wd_o, 32'hA5A5A5A5);
    chk("sb_rdata", rdm, 0);

    // LW 0x101 misaligned
    @(posedge clk); #1;
    MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h101;
    @(negedge clk);
    chk("mis_flag", {31'h0, MisalignM}, 1);
    chk("mis_dreq", {31'h0, dreq}, 0);
    chk("mis_stall", {31'h0, StallM}, 0);
    chk("mis_rdata", ReadDataM, 0);
    @(posedge clk); #1; clr_inputs();
    @(negedge clk);
    chk("mis_flag_clr", {31'h0, MisalignM}, 0);
    chk("mis_dreq_after", {31'h0, dreq}, 0);

    // LHU 0x402 then stray ack in IDLE
    access(1, 0, 3'b101, 32'h402, 0, 32'h98765432, 1);
    chk("lhu_dbe", {28'h0, be_o}, 4'b1100);
    chk("lhu_rdata", rdm, 32'h00009876);
    @(negedge clk); dack = 1; drdata = 32'hFFFFFFFF;
    @(negedge clk); dack = 0;
    chk("stray_dreq", {31'h0, dreq}, 0);
    chk("stray_stall", {31'h0, StallM}, 0);
    chk("stray_rdata", ReadDataM, 0);
    chk("stray_daddr", daddr, 32'h400);
    chk("stray_dbe", {28'h0, dbe}, 4'b1100);

    // reset while REQ outstanding
    @(posedge clk); #1;
    MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h500;
    @(negedge clk);
    chk("rreq_stall_idle", {31'h0, StallM}, 1);
    @(negedge clk);
    chk("rreq_dreq", {31'h0, dreq}, 1);
    #2 rst = 0;
    #1;
    chk("rreq_dreq_drop", {31'h0, dreq}, 0);
    chk("rreq_stall", {31'h0, StallM}, 0);
    chk("rreq_daddr", daddr, 0);
    @(posedge clk); #1;
    clr_inputs(); rst = 1;
    @(negedge clk); dack = 1; drdata = 32'hCAFEF00D;
    @(negedge clk); dack = 0;
    chk("late_ack_dreq", {31'h0, dreq}, 0);
    chk("late_ack_stall", {31'h0, StallM}, 0);
    chk("late_ack_rdata", ReadDataM, 0);

    access(1, 0, 3'b010, 32'h504, 0, 32'h0BADC0DE, 1);
    chk("post_rst_done", {31'h0, done_ok}, 1);
    chk("post_rst_daddr", a_o, 32'h504);
    chk("post_rst_stall_cyc", stall_n, 2);
    chk("post_rst_rdata", rdm, 32'h0BADC0DE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
